// File: rtl/fp_add_seq.sv
`default_nettype none
// ============================================================================
//  Module   : fp_add_seq
//  Purpose  : Multi-cycle IEEE 754 binary64 adder (a + b). Fixed 5-cycle
//             datapath UNPACK -> ALIGN -> ADD -> NORM -> ROUND with
//             round-to-nearest-even, denormal support and special values.
//  Ports    : clk      rising-edge clock
//             rst_n    asynchronous active-low reset
//             start    request, sampled only while idle
//             a, b     binary64 operands, captured on the accepting edge
//             result   a + b, held until the next completion
//             done     one-cycle pulse marking result valid
//             busy     high while an operation is in flight
//             invalid  NaN operand or Inf + (-Inf)
//             overflow finite result rounded to +/-Inf
//  Revision : 1.0  initial release
// ============================================================================
module fp_add_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] result,
    output logic        done,
    output logic        busy,
    output logic        invalid,
    output logic        overflow
);

    localparam logic [2:0]  S_IDLE   = 3'd0;
    localparam logic [2:0]  S_UNPACK = 3'd1;
    localparam logic [2:0]  S_ALIGN  = 3'd2;
    localparam logic [2:0]  S_ADD    = 3'd3;
    localparam logic [2:0]  S_NORM   = 3'd4;
    localparam logic [2:0]  S_ROUND  = 3'd5;
    localparam logic [63:0] C_QNAN   = 64'h7FF8_0000_0000_0000;

    logic [2:0]  r_state;
    logic [63:0] r_a, r_b;
    // UNPACK outputs
    logic        r_sa, r_sb;
    logic [10:0] r_ea, r_eb;
    logic [52:0] r_ma, r_mb;
    logic        r_spec, r_spec_inv;
    logic [63:0] r_spec_res;
    // ALIGN outputs
    logic        r_sl, r_sub, r_stk;
    logic [10:0] r_el;
    logic [52:0] r_ml;
    logic [54:0] r_msh;
    // ADD outputs
    logic [56:0] r_sum;
    logic        r_sr;
    logic [11:0] r_er;
    // NORM outputs
    logic [55:0] r_m;
    logic [11:0] r_en;
    logic        r_sn, r_zero;
    // registered outputs
    logic [63:0] r_result;
    logic        r_done, r_busy, r_invalid, r_overflow;

    // ------------------------------------------------------------------
    // UNPACK: field split, classification and special-value resolution
    // ------------------------------------------------------------------
    logic [10:0] w_ea_raw, w_eb_raw;
    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic        w_spec, w_spec_inv;
    logic [63:0] w_spec_res;

    always_comb begin
        w_ea_raw   = r_a[62:52];
        w_eb_raw   = r_b[62:52];
        w_a_nan    = (&w_ea_raw) & (|r_a[51:0]);
        w_b_nan    = (&w_eb_raw) & (|r_b[51:0]);
        w_a_inf    = (&w_ea_raw) & ~(|r_a[51:0]);
        w_b_inf    = (&w_eb_raw) & ~(|r_b[51:0]);
        w_a_zero   = ~(|r_a[62:0]);
        w_b_zero   = ~(|r_b[62:0]);
        w_spec     = 1'b1;
        w_spec_inv = 1'b0;
        w_spec_res = 64'd0;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (r_a[63] != r_b[63]))) begin
            w_spec_inv = 1'b1;
            w_spec_res = C_QNAN;
        end else if (w_a_inf) begin
            w_spec_res = r_a;
        end else if (w_b_inf) begin
            w_spec_res = r_b;
        end else if (w_a_zero && w_b_zero) begin
            // Only -0 + -0 keeps the negative sign.
            w_spec_res = {r_a[63] & r_b[63], 63'd0};
        end else begin
            w_spec = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // ALIGN: larger magnitude first, shift the smaller one right.
    // The smaller mantissa is placed at the top of a 111-bit field so that
    // every bit shifted past R (up to the 56-bit cap) stays visible for S.
    // ------------------------------------------------------------------
    logic         w_a_ge;
    logic [10:0]  w_el, w_es, w_diff;
    logic [52:0]  w_ml, w_ms;
    logic         w_sl;
    logic [5:0]   w_shamt;
    logic [110:0] w_wide;

    always_comb begin
        w_a_ge  = {r_ea, r_ma} >= {r_eb, r_mb};
        w_el    = w_a_ge ? r_ea : r_eb;
        w_es    = w_a_ge ? r_eb : r_ea;
        w_ml    = w_a_ge ? r_ma : r_mb;
        w_ms    = w_a_ge ? r_mb : r_ma;
        w_sl    = w_a_ge ? r_sa : r_sb;
        w_diff  = w_el - w_es;
        w_shamt = (w_diff > 11'd56) ? 6'd56 : w_diff[5:0];
        w_wide  = {w_ms, 58'd0} >> w_shamt;
    end

    // ------------------------------------------------------------------
    // ADD: 57-bit path {carry, hidden, frac[51:0], G, R, S}
    // ------------------------------------------------------------------
    logic [56:0] w_lop, w_sop, w_sum;

    always_comb begin
        w_lop = {1'b0, r_ml, 3'b000};
        w_sop = {1'b0, r_msh, r_stk};
        w_sum = r_sub ? (w_lop - w_sop) : (w_lop + w_sop);
    end

    // ------------------------------------------------------------------
    // NORM: right shift on carry, otherwise left shift by min(lz, exp-1).
    // A shift capped by the exponent leaves the hidden bit clear, which
    // is what marks the result as denormal for ROUND.
    // ------------------------------------------------------------------
    logic [5:0]  w_lz;
    logic [11:0] w_emax_sh, w_shift, w_en;
    logic [55:0] w_m;

    always_comb begin
        w_lz = 6'd56;
        for (int i = 0; i < 56; i++) begin
            if (r_sum[i]) begin
                w_lz = 6'(55 - i);
            end
        end
        w_emax_sh = r_er - 12'd1;
        w_shift   = ({6'd0, w_lz} > w_emax_sh) ? w_emax_sh : {6'd0, w_lz};
        if (r_sum[56]) begin
            w_m  = {r_sum[56:2], r_sum[1] | r_sum[0]};
            w_en = r_er + 12'd1;
        end else begin
            w_m  = r_sum[55:0] << w_shift;
            w_en = r_er - w_shift;
        end
    end

    // ------------------------------------------------------------------
    // ROUND: nearest-even, carry into exponent, overflow to Inf, pack.
    // ------------------------------------------------------------------
    logic        w_inc, w_ovf;
    logic [53:0] w_rnd;
    logic [11:0] w_ef;
    logic [51:0] w_frac;
    logic [63:0] w_res;

    always_comb begin
        w_inc = r_m[2] & (r_m[1] | r_m[0] | r_m[3]);
        w_rnd = {1'b0, r_m[55:3]} + {53'd0, w_inc};
        if (w_rnd[53]) begin
            w_ef   = r_en + 12'd1;
            w_frac = 52'd0;
        end else if (w_rnd[52]) begin
            w_ef   = r_en;
            w_frac = w_rnd[51:0];
        end else begin
            w_ef   = 12'd0;
            w_frac = w_rnd[51:0];
        end
        w_ovf = (w_ef >= 12'h7FF);
        if (r_zero) begin
            w_res = 64'd0;
        end else if (w_ovf) begin
            w_res = {r_sn, 11'h7FF, 52'd0};
        end else begin
            w_res = {r_sn, w_ef[10:0], w_frac};
        end
    end

    // ------------------------------------------------------------------
    // FSM and all state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_a        <= 64'd0;
            r_b        <= 64'd0;
            r_sa       <= 1'b0;
            r_sb       <= 1'b0;
            r_ea       <= 11'd0;
            r_eb       <= 11'd0;
            r_ma       <= 53'd0;
            r_mb       <= 53'd0;
            r_spec     <= 1'b0;
            r_spec_inv <= 1'b0;
            r_spec_res <= 64'd0;
            r_sl       <= 1'b0;
            r_sub      <= 1'b0;
            r_stk      <= 1'b0;
            r_el       <= 11'd0;
            r_ml       <= 53'd0;
            r_msh      <= 55'd0;
            r_sum      <= 57'd0;
            r_sr       <= 1'b0;
            r_er       <= 12'd0;
            r_m        <= 56'd0;
            r_en       <= 12'd0;
            r_sn       <= 1'b0;
            r_zero     <= 1'b0;
            r_result   <= 64'd0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_invalid  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_busy  <= 1'b1;
                        r_state <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    r_sa       <= r_a[63];
                    r_sb       <= r_b[63];
                    r_ea       <= (w_ea_raw == 11'd0) ? 11'd1 : w_ea_raw;
                    r_eb       <= (w_eb_raw == 11'd0) ? 11'd1 : w_eb_raw;
                    r_ma       <= {|w_ea_raw, r_a[51:0]};
                    r_mb       <= {|w_eb_raw, r_b[51:0]};
                    r_spec     <= w_spec;
                    r_spec_inv <= w_spec_inv;
                    r_spec_res <= w_spec_res;
                    r_state    <= S_ALIGN;
                end
                S_ALIGN: begin
                    r_sl    <= w_sl;
                    r_sub   <= r_sa ^ r_sb;
                    r_el    <= w_el;
                    r_ml    <= w_ml;
                    r_msh   <= w_wide[110:56];
                    r_stk   <= |w_wide[55:0];
                    r_state <= S_ADD;
                end
                S_ADD: begin
                    r_sum   <= w_sum;
                    r_sr    <= r_sl;
                    r_er    <= {1'b0, r_el};
                    r_state <= S_NORM;
                end
                S_NORM: begin
                    r_m     <= w_m;
                    r_en    <= w_en;
                    r_sn    <= r_sr;
                    r_zero  <= (r_sum == 57'd0);
                    r_state <= S_ROUND;
                end
                S_ROUND: begin
                    if (r_spec) begin
                        r_result   <= r_spec_res;
                        r_invalid  <= r_spec_inv;
                        r_overflow <= 1'b0;
                    end else begin
                        r_result   <= w_res;
                        r_invalid  <= 1'b0;
                        r_overflow <= w_ovf & ~r_zero;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign result   = r_result;
    assign done     = r_done;
    assign busy     = r_busy;
    assign invalid  = r_invalid;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fp_add_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_add_seq
//  Purpose  : Self-checking bench for fp_add_seq. Directed operations push
//             their expected result into a scoreboard queue; a monitor pops
//             and compares on every done pulse. Handshake timing, operand
//             stability while busy and reset abort are checked inline.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp_add_seq;

    typedef struct {
        logic [63:0] res;
        logic        inv;
        logic        ovf;
        string       tag;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] result;
    logic        done;
    logic        busy;
    logic        invalid;
    logic        overflow;

    exp_t sb_q[$];
    int   n_vec;
    int   n_fail;

    fp_add_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .result   (result),
        .done     (done),
        .busy     (busy),
        .invalid  (invalid),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && done === 1'b1) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $error("FAIL spurious_done: result=%h with empty scoreboard", result);
            end else begin
                e = sb_q.pop_front();
                assert ({result, invalid, overflow} === {e.res, e.inv, e.ovf}) else begin
                    n_fail++;
                    $error("FAIL %s: got result=%h inv=%b ovf=%b, want result=%h inv=%b ovf=%b",
                           e.tag, result, invalid, overflow, e.res, e.inv, e.ovf);
                end
            end
        end
    end

    task automatic push_exp(input logic [63:0] r, input logic i, input logic o, input string tag);
        exp_t e;
        e.res = r;
        e.inv = i;
        e.ovf = o;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    // One operation: drive at a negedge, check busy/done timing, scramble
    // operands while busy, and confirm the result is held afterwards.
    task automatic do_op(input logic [63:0] ta, input logic [63:0] tb_v,
                         input logic [63:0] er, input logic ei, input logic eo,
                         input string tag);
        int got;
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        push_exp(er, ei, eo, tag);
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = {$urandom, $urandom};
        b     = {$urandom, $urandom};
        got   = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = c;
                break;
            end
            if (c < 5) begin
                n_vec++;
                assert (busy === 1'b1) else begin
                    n_fail++;
                    $error("FAIL %s_busy: busy=%b in cycle %0d, want 1", tag, busy, c + 1);
                end
            end
        end
        n_vec++;
        assert (got === 5) else begin
            n_fail++;
            $error("FAIL %s_latency: done seen at offset %0d, want 5 (-1 = timeout)", tag, got);
        end
        n_vec++;
        assert (busy === 1'b0) else begin
            n_fail++;
            $error("FAIL %s_busy_clr: busy=%b at done, want 0", tag, busy);
        end
        @(negedge clk);
        n_vec++;
        assert ({done, result} === {1'b0, er}) else begin
            n_fail++;
            $error("FAIL %s_hold: done=%b result=%h, want done=0 result=%h", tag, done, result, er);
        end
    endtask

    logic [63:0] hs_b   [3];
    logic [63:0] hs_exp [3];

    initial begin
        n_vec  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = 64'd0;
        b      = 64'd0;
        hs_b[0]   = 64'h3FF0_0000_0000_0000;  // 1.0
        hs_b[1]   = 64'h4000_0000_0000_0000;  // 2.0
        hs_b[2]   = 64'h4008_0000_0000_0000;  // 3.0
        hs_exp[0] = 64'h4000_0000_0000_0000;  // 2.0
        hs_exp[1] = 64'h4008_0000_0000_0000;  // 3.0
        hs_exp[2] = 64'h4010_0000_0000_0000;  // 4.0

        // Reset state
        repeat (3) @(negedge clk);
        n_vec++;
        assert ({result, done, busy, invalid, overflow} === 68'd0) else begin
            n_fail++;
            $error("FAIL reset_state: result=%h done=%b busy=%b inv=%b ovf=%b, want all 0",
                   result, done, busy, invalid, overflow);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Directed arithmetic
        do_op(64'h4059_0000_0000_0000, 64'hC040_8000_0000_0000, 64'h4050_C000_0000_0000, 1'b0, 1'b0, "100_plus_m33");
        do_op(64'h3FB9_9999_9999_999A, 64'h3FC9_9999_9999_999A, 64'h3FD3_3333_3333_3334, 1'b0, 1'b0, "p1_plus_p2");
        do_op(64'h3FF0_0000_0000_0000, 64'hBFF0_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0, 1'b0, "cancel");
        do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, "negz_negz");
        do_op(64'h0000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0, 1'b0, "posz_negz");
        do_op(64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 1'b0, 1'b0, "denorm_sum");
        do_op(64'h000F_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'h0010_0000_0000_0000, 1'b0, 1'b0, "denorm_to_norm");
        do_op(64'h3FF0_0000_0000_0000, 64'h3CA0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b0, 1'b0, "tie_even");
        do_op(64'h7FEF_FFFF_FFFF_FFFF, 64'h7FEF_FFFF_FFFF_FFFF, 64'h7FF0_0000_0000_0000, 1'b0, 1'b1, "overflow");
        do_op(64'h7FF0_0000_0000_0000, 64'hFFF0_0000_0000_0000, 64'h7FF8_0000_0000_0000, 1'b1, 1'b0, "inf_minus_inf");
        do_op(64'h7FF8_0000_0000_0000, 64'h3FF0_0000_0000_0000, 64'h7FF8_0000_0000_0000, 1'b1, 1'b0, "nan_operand");
        do_op(64'h7FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h7FF0_0000_0000_0000, 1'b0, 1'b0, "inf_plus_2");

        // start held high: captures at E0, E6, E12 only
        a     = 64'h3FF0_0000_0000_0000;
        start = 1'b1;
        for (int c = 0; c < 18; c++) begin
            if (c % 6 == 0) begin
                b = hs_b[c / 6];
                push_exp(hs_exp[c / 6], 1'b0, 1'b0, "held_start");
            end else begin
                b = 64'h4024_0000_0000_0000;  // 10.0: would show up if wrongly captured
            end
            @(posedge clk);
            @(negedge clk);
            n_vec++;
            assert (done === (c % 6 == 5)) else begin
                n_fail++;
                $error("FAIL held_start_done: done=%b after edge %0d, want %b", done, c, (c % 6 == 5));
            end
        end
        start = 1'b0;
        @(negedge clk);

        // Reset mid-operation aborts without a done pulse
        a     = 64'h4059_0000_0000_0000;
        b     = 64'h4059_0000_0000_0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        assert ({result, done, busy, invalid, overflow} === 68'd0) else begin
            n_fail++;
            $error("FAIL abort_reset: result=%h done=%b busy=%b inv=%b ovf=%b, want all 0",
                   result, done, busy, invalid, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_vec++;
            assert (done === 1'b0) else begin
                n_fail++;
                $error("FAIL abort_no_done: done=%b %0d cycles after reset, want 0", done, c);
            end
        end
        do_op(64'h4000_0000_0000_0000, 64'hC008_0000_0000_0000, 64'hBFF0_0000_0000_0000, 1'b0, 1'b0, "after_reset");

        repeat (3) @(negedge clk);
        n_vec++;
        assert (sb_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_add_seq.md
# fp_add_seq

Multi-cycle IEEE 754 double-precision adder (a + b) with a start/done handshake. It is the additive counterpart to the combinational subtractor in the FPU. It runs a fixed 5-stage sequential datapath with round-to-nearest-even, full denormal support and special-value handling. It sits beside the combinational units and is used where registered, fixed-latency results are required.

## Interface
- No parameters; the operand format is fixed at binary64.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request. Sampled only while idle.
- a  input  64  operand A, IEEE 754 binary64. Captured on the accepting edge.
- b  input  64  operand B, IEEE 754 binary64. Captured on the accepting edge.
- result  output  64  sum a + b. Held until the next completion.
- done  output  1  single-cycle pulse marking result valid.
- busy  output  1  high while an operation is in flight.
- invalid  output  1  NaN operand or Inf + (−Inf). Valid with done and held with result.
- overflow  output  1  finite result rounded to ±Inf. Valid with done and held with result.

## Operation
- FSM states: IDLE → UNPACK → ALIGN → ADD → NORM → ROUND → IDLE. Each state lasts one cycle. There is no data-dependent latency.
- IDLE:
  - start=1 latches a and b.
  - busy is set and the FSM moves to UNPACK.
- UNPACK:
  - Split each operand into sign, exponent and 52-bit fraction.
  - Hidden bit is 1 if exp≠0, else 0. Denormals use an effective exponent of 1.
  - Classify each operand as zero, denormal, normal, Inf or NaN.
- ALIGN:
  - Swap operands so the operand with the larger magnitude is first.
  - Right-shift the smaller mantissa by the exponent difference, capped at 56.
  - Keep guard and round bits, and OR all shifted-out bits into sticky.
- ADD:
  - Use a 57-bit mantissa path: carry, hidden bit, 52 fraction bits, G, R, S.
  - Same signs: add. Different signs: subtract the smaller from the larger.
  - The result sign is the sign of the larger-magnitude operand.
- NORM:
  - Carry out: shift right 1 with the shifted-out bit ORed into sticky, and add 1 to the exponent.
  - Otherwise: leading-zero count, then a left shift of min(lz, exp−1) in a single cycle.
  - The result becomes denormal (exp=0) when the exponent would drop below 1.
- ROUND:
  - Round to nearest, ties to even, using G, R, S and the LSB.
  - A mantissa carry out of rounding increments the exponent.
  - An exponent ≥ 0x7FF gives ±Inf and sets overflow=1.
  - Pack the result, pulse done and clear busy.
- Special cases are evaluated in UNPACK, carried through the pipeline, and override the datapath in ROUND:
  - Any NaN operand → result 0x7FF8000000000000, invalid=1.
  - +Inf + −Inf → result 0x7FF8000000000000, invalid=1.
  - Inf + finite → that Inf.
  - Exact cancellation (x + (−x)) → +0.
  - −0 + −0 → −0. +0 + −0 → +0.
- start while busy is ignored. Operands are not re-captured, and there is no queueing.

## Timing
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE.
  - result=0, done=0, busy=0, invalid=0, overflow=0.
  - All internal registers are cleared.
- Reset during an operation aborts it. No done is produced for the aborted operation.
- Edge numbering: E0 is the rising edge at which start=1 is sampled in IDLE.
  - After E0, busy=1.
  - After E5, result, invalid and overflow are updated, done=1 and busy=0.
  - After E6, done=0.
- Latency is 5 cycles from capture to result.
- Throughput:
  - start sampled at E5 is ignored, because the FSM is still in ROUND at that edge.
  - The earliest next capture is E6, giving 1 operation per 6 cycles.
- Between completions, result and the flags are stable.
- a and b may change freely after E0.

## Test plan
- 100 + (−33): a=0x4059000000000000, b=0xC040800000000000 → result 0x4050C00000000000 after exactly 5 cycles, done high for one cycle, busy high for cycles 1–5.
- 0.1 + 0.2: a=0x3FB999999999999A, b=0x3FC999999999999A → result 0x3FD3333333333334 (RNE tie handling).
- Cancellation and zeros:
  - 1.0 + (−1.0) → 0x0000000000000000.
  - 0x8000000000000000 + 0x8000000000000000 → 0x8000000000000000.
- Denormal and overflow:
  - 0x0000000000000001 + 0x0000000000000001 → 0x0000000000000002.
  - 0x7FEFFFFFFFFFFFFF + 0x7FEFFFFFFFFFFFFF → 0x7FF0000000000000, overflow=1.
- Specials:
  - 0x7FF0000000000000 + 0xFFF0000000000000 → 0x7FF8000000000000, invalid=1.
  - 0x7FF8000000000000 + 1.0 → 0x7FF8000000000000, invalid=1.
  - Inf + 2.0 → 0x7FF0000000000000, invalid=0.
- Handshake and reset:
  - start held high continuously → captures only at E0, E6, E12…
  - Operand changes while busy do not affect the result.
  - rst_n pulsed low at cycle 3 → all outputs 0 and no done. A fresh start afterwards completes normally.
